// File: rtl/vga_text_writer.sv
// vga_text_writer: terminal byte stream to 80x25 text VRAM over a Wishbone initiator port.
module vga_text_writer #(
  parameter int          COLS      = 80,
  parameter int          ROWS      = 25,
  parameter int          FIRST_ROW = 1,
  parameter logic [15:0] BASE_ADR  = 16'o0,
  parameter logic [7:0]  BLANK     = 8'h20
)(
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic [7:0]  ch_i,
  input  logic        ch_valid_i,
  output logic        ch_ready_o,
  output logic [15:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [1:0]  wb_sel_o,
  input  logic        wb_ack_i,
  output logic [12:0] cursor,
  output logic        busy
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [RW-1:0] TOP_ROW  = RW'(FIRST_ROW);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [15:0] TOP_OFS = 16'(FIRST_ROW * COLS);
  localparam logic [15:0] ROW_LEN = 16'(COLS);
  localparam logic [15:0] SCR_END = 16'((ROWS - 1) * COLS - 2);
  localparam logic [15:0] CLR_END = 16'(ROWS * COLS - 2);
  typedef enum logic [2:0] {IDLE, PUTC, SCR_RD, SCR_WR, CLR_WR} state_t;
  state_t        state, state_n;
  logic [CW-1:0] col, col_n;
  logic [RW-1:0] row, row_n;
  logic [15:0]   ofs, ofs_n, rd_dat;
  logic [12:0]   cur;
  logic [7:0]    ch;
  logic          acc, accept, ack, nl;
  assign ch_ready_o = (state == IDLE) && !acc;
  assign busy       = ~ch_ready_o;
  assign wb_stb_o   = wb_cyc_o;
  assign accept     = ch_valid_i & ch_ready_o;
  assign ack        = wb_cyc_o & wb_ack_i;
  assign cur        = 13'(row) * 13'(COLS) + 13'(col);
  // nl folds explicit LF and auto-wrap into one newline path (advance row or scroll)
  always_comb begin
    state_n = state;
    col_n   = col;
    row_n   = row;
    ofs_n   = ofs;
    nl      = 1'b0;
    case (state)
      IDLE:
        if (accept) begin
          if (ch_i == 8'h0D) col_n = '0;
          else if (ch_i == 8'h0A) nl = 1'b1;
          else if (ch_i == 8'h08) col_n = (col != '0) ? col - CW'(1) : col;
          else if (ch_i == 8'h0C) begin
            state_n = CLR_WR;
            ofs_n   = TOP_OFS;
            col_n   = '0;
            row_n   = TOP_ROW;
          end else state_n = PUTC;
        end
      PUTC:
        if (ack) begin
          state_n = IDLE;
          col_n   = (col == LAST_COL) ? '0 : col + CW'(1);
          nl      = (col == LAST_COL);
        end
      SCR_RD: state_n = ack ? SCR_WR : SCR_RD;
      SCR_WR:
        if (ack) begin
          ofs_n   = ofs + 16'd2;
          state_n = (ofs == SCR_END) ? CLR_WR : SCR_RD;
        end
      CLR_WR:
        if (ack) begin
          ofs_n   = ofs + 16'd2;
          state_n = (ofs == CLR_END) ? IDLE : CLR_WR;
        end
      default: state_n = IDLE;
    endcase
    if (nl) begin
      if (row != LAST_ROW) row_n = row + RW'(1);
      else begin
        state_n = SCR_RD;
        ofs_n   = TOP_OFS;
      end
    end
  end
  // scroll copy ends exactly where the last-row clear begins, so ofs runs on into CLR_WR
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      state    <= IDLE;
      col      <= '0;
      row      <= TOP_ROW;
      ofs      <= '0;
      ch       <= '0;
      acc      <= 1'b0;
      rd_dat   <= '0;
      wb_cyc_o <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_we_o  <= 1'b0;
      wb_sel_o <= 2'b00;
      cursor   <= 13'(FIRST_ROW * COLS);
    end else begin
      state  <= state_n;
      col    <= col_n;
      row    <= row_n;
      ofs    <= ofs_n;
      acc    <= accept;
      cursor <= cur;
      if (accept) ch <= ch_i;
      if (ack) begin
        wb_cyc_o <= 1'b0;
        if (state == SCR_RD) rd_dat <= wb_dat_i;
      end else if (!wb_cyc_o && state != IDLE) begin
        wb_cyc_o <= 1'b1;
        wb_we_o  <= (state != SCR_RD);
        wb_adr_o <= BASE_ADR + ((state == PUTC) ? {3'b000, cur} : (state == SCR_RD) ? ofs + ROW_LEN : ofs);
        wb_dat_o <= (state == PUTC) ? {ch, ch} : (state == SCR_WR) ? rd_dat : {BLANK, BLANK};
        wb_sel_o <= (state != PUTC) ? 2'b11 : cur[0] ? 2'b10 : 2'b01;
      end
    end
  end
endmodule

// File: tb/tb_vga_text_writer.sv
// tb_vga_text_writer: directed checks of vga_text_writer against a byte-lane VRAM responder.
module tb_vga_text_writer;
  logic        wb_clk_i = 1'b0;
  logic        wb_rst_n = 1'b0;
  logic [7:0]  ch_i = 8'h00;
  logic        ch_valid_i = 1'b0;
  logic        ch_ready_o, wb_cyc_o, wb_stb_o, wb_we_o, busy;
  logic [15:0] wb_adr_o, wb_dat_o;
  logic [15:0] wb_dat_i = 16'h0000;
  logic [1:0]  wb_sel_o;
  logic        wb_ack_i = 1'b0;
  logic [12:0] cursor;
  int n_chk = 0, n_err = 0;
  int stall = 0, wcnt = 0;
  typedef struct packed {logic we; logic [1:0] sel; logic [15:0] adr; logic [15:0] dat;} xfer_t;
  xfer_t      log_q[$];
  logic [7:0] mem [4096];
  logic [7:0] snap [4096];

  vga_text_writer dut (
    .wb_clk_i(wb_clk_i), .wb_rst_n(wb_rst_n), .ch_i(ch_i), .ch_valid_i(ch_valid_i),
    .ch_ready_o(ch_ready_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_ack_i(wb_ack_i), .cursor(cursor), .busy(busy)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // registered, self-clearing ack after `stall` wait cycles
  always @(posedge wb_clk_i) begin
    if (wb_ack_i) wb_ack_i <= 1'b0;
    else if (wb_cyc_o && wb_stb_o) begin
      if (wcnt < stall) wcnt <= wcnt + 1;
      else begin
        wcnt     <= 0;
        wb_ack_i <= 1'b1;
        log_q.push_back({wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o});
        if (wb_we_o) begin
          if (wb_sel_o[0]) mem[{wb_adr_o[11:1], 1'b0}] <= wb_dat_o[7:0];
          if (wb_sel_o[1]) mem[{wb_adr_o[11:1], 1'b1}] <= wb_dat_o[15:8];
        end else wb_dat_i <= {mem[{wb_adr_o[11:1], 1'b1}], mem[{wb_adr_o[11:1], 1'b0}]};
      end
    end else wcnt <= 0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] c);
    int t = 0;
    while (!ch_ready_o && t < 20000) begin
      @(negedge wb_clk_i);
      t++;
    end
    if (!ch_ready_o) check("send_ready", 32'(ch_ready_o), 1);
    ch_i = c;
    ch_valid_i = 1'b1;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    ch_valid_i = 1'b0;
  endtask

  task automatic settle();
    int t = 0;
    while (!ch_ready_o && t < 20000) begin
      @(negedge wb_clk_i);
      t++;
    end
    if (!ch_ready_o) check("idle_timeout", 32'(ch_ready_o), 1);
    @(negedge wb_clk_i);
  endtask

  initial begin
    int l, hi;
    logic bad;
    logic [15:0] a, d;
    logic [1:0] s;
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 7 + 3);
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_n = 1'b1;
    check("rst_cursor", 32'(cursor), 80);
    check("rst_ready", 32'(ch_ready_o), 1);
    check("rst_cyc", 32'(wb_cyc_o), 0);
    check("rst_sel", 32'(wb_sel_o), 0);
    // T2: printable characters and byte-lane selection
    send(8'h41);
    check("a_ready_drop", 32'(ch_ready_o), 0);
    @(negedge wb_clk_i);
    check("a_stb", 32'(wb_stb_o), 1);
    check("a_adr", 32'(wb_adr_o), 80);
    check("a_dat", 32'(wb_dat_o), 16'h4141);
    check("a_sel", 32'(wb_sel_o), 2'b01);
    check("a_we", 32'(wb_we_o), 1);
    @(negedge wb_clk_i);
    check("a_ready_n2", 32'(ch_ready_o), 0);
    @(negedge wb_clk_i);
    check("a_ready_n3", 32'(ch_ready_o), 1);
    check("a_cyc_n3", 32'(wb_cyc_o), 0);
    @(negedge wb_clk_i);
    check("a_cursor", 32'(cursor), 81);
    check("a_mem", 32'(mem[80]), 8'h41);
    send(8'h42);
    @(negedge wb_clk_i);
    check("b_adr", 32'(wb_adr_o), 81);
    check("b_sel", 32'(wb_sel_o), 2'b10);
    check("b_dat", 32'(wb_dat_o), 16'h4242);
    settle();
    check("b_cursor", 32'(cursor), 82);
    check("b_mem", 32'(mem[81]), 8'h42);
    // T3: control codes without bus traffic
    repeat (3) send(8'h43);
    settle();
    check("c_cursor", 32'(cursor), 85);
    l = log_q.size();
    send(8'h0D);
    check("cr_ready_drop", 32'(ch_ready_o), 0);
    @(negedge wb_clk_i);
    check("cr_ready_back", 32'(ch_ready_o), 1);
    check("cr_cursor", 32'(cursor), 80);
    send(8'h0A);
    settle();
    check("lf_cursor", 32'(cursor), 160);
    send(8'h08);
    settle();
    check("bs0_cursor", 32'(cursor), 160);
    repeat (3) send(8'h44);
    send(8'h08);
    settle();
    check("bs3_cursor", 32'(cursor), 162);
    check("ctrl_no_bus", 32'(log_q.size() - l), 3);
    // T4: wrap at the bottom-right corner triggers a scroll
    send(8'h0D);
    repeat (22) send(8'h0A);
    repeat (79) send(8'h61);
    settle();
    check("corner_cursor", 32'(cursor), 1999);
    for (int i = 0; i < 4096; i++) snap[i] = mem[i];
    l = log_q.size();
    send(8'h5A);
    settle();
    check("scr_count", 32'(log_q.size() - l), 1881);
    check("scr_z_adr", 32'(log_q[l].adr), 1999);
    check("scr_z_sel", 32'(log_q[l].sel), 2'b10);
    check("scr_rd0", 32'({log_q[l+1].we, log_q[l+1].adr}), 32'(160));
    check("scr_wr0", 32'({log_q[l+2].we, log_q[l+2].sel, log_q[l+2].adr}), {13'd0, 3'b111, 16'd80});
    check("scr_wr0_dat", 32'(log_q[l+2].dat), {snap[161], snap[160]});
    check("scr_rdn", 32'({log_q[l+1839].we, log_q[l+1839].adr}), 32'(1998));
    check("scr_wrn", 32'(log_q[l+1840].adr), 1918);
    check("scr_wrn_dat", 32'(log_q[l+1840].dat), {8'h5A, snap[1998]});
    check("clr_first", 32'({log_q[l+1841].adr, log_q[l+1841].dat}), {16'd1920, 16'h2020});
    check("clr_last", 32'({log_q[l+1880].adr, log_q[l+1880].dat}), {16'd1998, 16'h2020});
    check("scr_cursor", 32'(cursor), 1920);
    check("scr_mem80", 32'(mem[80]), 32'(snap[160]));
    check("scr_mem1919", 32'(mem[1919]), 8'h5A);
    check("scr_mem1999", 32'(mem[1999]), 8'h20);
    check("scr_row0", 32'(mem[40]), 32'(snap[40]));
    // T5: form feed clears the terminal rows only
    l = log_q.size();
    send(8'h0C);
    settle();
    check("ff_count", 32'(log_q.size() - l), 960);
    check("ff_first", 32'({log_q[l].sel, log_q[l].adr, log_q[l].dat}), {2'b11, 16'd80, 16'h2020});
    check("ff_last", 32'(log_q[l+959].adr), 1998);
    check("ff_cursor", 32'(cursor), 80);
    check("ff_row0_0", 32'(mem[0]), 8'h03);
    check("ff_row0_79", 32'(mem[79]), 8'(79 * 7 + 3));
    check("ff_mem1000", 32'(mem[1000]), 8'h20);
    // T6: stalled ack with ch_valid_i held high
    stall = 5;
    l = log_q.size();
    ch_i = 8'h51;
    ch_valid_i = 1'b1;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    ch_i = 8'h52;
    hi = 0;
    while (!wb_stb_o && hi < 10) begin
      @(negedge wb_clk_i);
      hi++;
    end
    a = wb_adr_o; d = wb_dat_o; s = wb_sel_o;
    hi = 0;
    bad = 1'b0;
    while (wb_stb_o && hi < 50) begin
      if (wb_adr_o != a || wb_dat_o != d || wb_sel_o != s || !wb_cyc_o) bad = 1'b1;
      hi++;
      @(negedge wb_clk_i);
    end
    check("stall_stable", 32'(bad), 0);
    check("stall_len", 32'(hi), 7);
    check("stall_adr", 32'(a), 80);
    hi = 0;
    while (!ch_ready_o && hi < 20) begin
      @(negedge wb_clk_i);
      hi++;
    end
    ch_valid_i = 1'b0;
    check("stall_one_accept", 32'(log_q.size() - l), 1);
    @(negedge wb_clk_i);
    check("stall_cursor", 32'(cursor), 81);
    stall = 0;
    // T1b: reset in the middle of a scroll
    repeat (24) send(8'h0A);
    repeat (100) @(negedge wb_clk_i);
    check("mid_busy", 32'(busy), 1);
    wb_rst_n = 1'b0;
    @(negedge wb_clk_i);
    check("mrst_cyc", 32'(wb_cyc_o), 0);
    check("mrst_cursor", 32'(cursor), 80);
    check("mrst_ready", 32'(ch_ready_o), 1);
    @(negedge wb_clk_i);
    wb_rst_n = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    check("mrst_cyc2", 32'(wb_cyc_o), 0);
    check("mrst_cursor2", 32'(cursor), 80);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
